// File: rtl/nibble_serial_alu_pkg.sv
// Shared definitions for the nibble-serial ALU: nibble width, opcode and FSM state encodings.
package nibble_serial_alu_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHR = 3'b110,
      OP_SHL = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_nibble.sv
// Combinational 4-bit ALU slice: arithmetic, logic, 1-bit shifts with an external fill bit,
// and an unsigned magnitude compare of the two nibbles.
module alu_nibble
   import nibble_serial_alu_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  op_e              op,
   input  logic             cin,
   input  logic             fill,
   output logic [NIB_W-1:0] y,
   output logic             cout,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   logic [NIB_W-1:0] w_b_eff;
   logic [NIB_W:0]   w_sum;

   // Subtraction is a + ~b + cin, so the adder is shared between ADD and SUB.
   assign w_b_eff = (op == OP_SUB) ? ~b : b;
   assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{NIB_W{1'b0}}, cin};

   assign lt = (a < b);
   assign eq = (a == b);
   assign gt = (a > b);

   // Result and carry-out selection per opcode.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
      y    = '0;
      cout = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            y    = w_sum[NIB_W-1:0];
            cout = w_sum[NIB_W];
         end
         OP_AND: y = a & b;
         OP_OR:  y = a | b;
         OP_XOR: y = a ^ b;
         OP_NOT: y = ~a;
         OP_SHR: begin
            y    = {fill, a[NIB_W-1:1]};
            cout = a[0];
         end
         OP_SHL: begin
            y    = {a[NIB_W-2:0], fill};
            cout = a[NIB_W-1];
         end
         default: begin
            y    = '0;
            cout = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/nibble_serial_alu.sv
// Nibble-serial ALU: accepts one operation in IDLE, processes one nibble per cycle LSB first
// in RUN, and holds the registered result in DONE until the consumer takes it.
// Optional feature macro: NIBBLE_ALU_FLAGS_EN adds out_zero and out_ovf.
module nibble_serial_alu
   import nibble_serial_alu_pkg::*;
#(
   parameter int NIBBLES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_op,
   input  logic [NIBBLES*NIB_W-1:0] in_a,
   input  logic [NIBBLES*NIB_W-1:0] in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NIBBLES*NIB_W-1:0] out_res,
   output logic                     out_carry,
`ifdef NIBBLE_ALU_FLAGS_EN
   output logic                     out_zero,
   output logic                     out_ovf,
`endif
   output logic                     out_less,
   output logic                     out_equal,
   output logic                     out_more
);

   localparam int DATA_W = NIBBLES * NIB_W;
   localparam int IDX_W  = $clog2(NIBBLES);

   state_e            r_state;
   op_e               r_op;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [IDX_W-1:0]  r_idx;
   logic              r_carry;
   logic [DATA_W-1:0] r_res;
   logic              r_less;
   logic              r_equal;
   logic              r_more;

   logic [IDX_W+1:0]  w_base;
   logic [DATA_W-1:0] w_shr;
   logic [DATA_W-1:0] w_shl;
   logic              w_fill;
   logic              w_cin;
   logic              w_last;
   logic [NIB_W-1:0]  w_y;
   logic              w_cout;
   logic              w_lt;
   logic              w_eq;
   logic              w_gt;
   logic              w_less_next;
   logic              w_more_next;
   logic              w_carry_next;
   logic [DATA_W-1:0] w_res_next;

   // Bit offset of the current nibble (nibble width 4 => index * 4).
   assign w_base = {r_idx, 2'b00};
   assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

   // Whole-word shifts of the latched operand supply each nibble's fill bit; the vacated
   // end positions are already 0, which gives the MSB/LSB fill of 0 for free.
   assign w_shr  = r_a >> 1;
   assign w_shl  = r_a << 1;
   assign w_fill = (r_op == OP_SHL) ? w_shl[w_base] : w_shr[w_base + 3];

   // First nibble of SUB starts with carry-in 1 (two's complement); ADD starts with 0.
   assign w_cin  = (r_idx == '0) ? (r_op == OP_SUB) : r_carry;

   alu_nibble u_slice (
      .a    (r_a[w_base +: NIB_W]),
      .b    (r_b[w_base +: NIB_W]),
      .op   (r_op),
      .cin  (w_cin),
      .fill (w_fill),
      .y    (w_y),
      .cout (w_cout),
      .lt   (w_lt),
      .eq   (w_eq),
      .gt   (w_gt)
   );

   // A differing higher nibble overrides whatever the lower nibbles decided.
   assign w_less_next  = w_lt | (r_less & w_eq);
   assign w_more_next  = w_gt | (r_more & w_eq);

   // SHR reports the bit shifted out of nibble 0, so later nibbles must not overwrite it.
   assign w_carry_next = (r_op == OP_SHR && r_idx != '0) ? r_carry : w_cout;

   // Result word with the current nibble substituted.
   always_comb begin
      w_res_next                   = r_res;
      w_res_next[w_base +: NIB_W]  = w_y;
   end

   // Control FSM plus operand latch and per-nibble result/flag accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_op    <= OP_ADD;
         r_a     <= '0;
         r_b     <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_res   <= '0;
         r_less  <= 1'b0;
         r_equal <= 1'b0;
         r_more  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_op    <= op_e'(in_op);
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_idx   <= '0;
                  r_carry <= 1'b0;
                  r_res   <= '0;
                  r_less  <= 1'b0;
                  r_equal <= 1'b0;
                  r_more  <= 1'b0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_res   <= w_res_next;
               r_carry <= w_carry_next;
               r_less  <= w_less_next;
               r_more  <= w_more_next;
               if (w_last) begin
                  r_equal <= ~(w_less_next | w_more_next);
                  r_idx   <= '0;
                  r_state <= DONE;
               end else begin
                  r_idx   <= r_idx + IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef NIBBLE_ALU_FLAGS_EN
   logic r_zero;
   logic r_ovf;
   logic w_a_msb;
   logic w_b_msb;

   assign w_a_msb = r_a[DATA_W-1];
   assign w_b_msb = r_b[DATA_W-1];

   // Zero and signed-overflow flags, captured when the top nibble is produced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zero <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (r_state == IDLE && in_valid) begin
         r_zero <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (r_state == RUN && w_last) begin
         r_zero <= (w_res_next == '0);
         case (r_op)
            OP_ADD:  r_ovf <= (w_a_msb == w_b_msb) && (w_y[NIB_W-1] != w_a_msb);
            OP_SUB:  r_ovf <= (w_a_msb != w_b_msb) && (w_y[NIB_W-1] != w_a_msb);
            default: r_ovf <= 1'b0;
         endcase
      end
   end

   assign out_zero = r_zero;
   assign out_ovf  = r_ovf;
`endif

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign out_res   = r_res;
   assign out_carry = r_carry;
   assign out_less  = r_less;
   assign out_equal = r_equal;
   assign out_more  = r_more;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Self-checking bench for nibble_serial_alu (default build, NIBBLES = 2): a word-level
// reference model pushes expected results into a queue at request time, popped when
// out_valid rises.
module tb_nibble_serial_alu;

   localparam int NIBBLES = 2;
   localparam int DATA_W  = 4 * NIBBLES;

   typedef struct packed {
      logic [DATA_W-1:0] res;
      logic              carry;
      logic              lt;
      logic              eq;
      logic              gt;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        in_op = '0;
   logic [DATA_W-1:0] in_a = '0;
   logic [DATA_W-1:0] in_b = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_res;
   logic              out_carry;
   logic              out_less;
   logic              out_equal;
   logic              out_more;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb_q[$];

   nibble_serial_alu #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_carry (out_carry),
      .out_less  (out_less),
      .out_equal (out_equal),
      .out_more  (out_more)
   );

   always #5 clk = ~clk;

   // Word-level reference model.
   function automatic exp_t model(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b);
      exp_t            m;
      logic [DATA_W:0] s;
      m.lt    = (a < b);
      m.eq    = (a == b);
      m.gt    = (a > b);
      m.carry = 1'b0;
      m.res   = '0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; m.res = s[DATA_W-1:0]; m.carry = s[DATA_W]; end
         3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 1; m.res = s[DATA_W-1:0]; m.carry = s[DATA_W]; end
         3'd2: m.res = a & b;
         3'd3: m.res = a | b;
         3'd4: m.res = a ^ b;
         3'd5: m.res = ~a;
         3'd6: begin m.res = a >> 1; m.carry = a[0]; end
         default: begin m.res = a << 1; m.carry = a[DATA_W-1]; end
      endcase
      return m;
   endfunction

   function automatic exp_t observed();
      return {out_res, out_carry, out_less, out_equal, out_more};
   endfunction

   // One full transaction: request, latency check, result check, optional backpressure, release.
   task automatic run_op(input logic [2:0] op, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input int hold, input string tag);
      exp_t e;
      exp_t got;
      int   lat;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         $display("FAIL %s in_ready_idle: got %b want 1", tag, in_ready);
         n_bad++;
      end
      in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
      sb_q.push_back(model(op, a, b));
      @(posedge clk); #1;
      // Scramble the inputs after accept: the block must use its latched copy.
      in_valid = 1'b0; in_op = ~op; in_a = ~a; in_b = ~b;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      n_cmp++;
      if (lat != NIBBLES) begin
         $display("FAIL %s latency: got %0d edges want %0d", tag, lat, NIBBLES);
         n_bad++;
      end
      e   = sb_q.pop_front();
      got = observed();
      n_cmp++;
      if (got !== e) begin
         $display("FAIL %s result: got res=%h c=%b l/e/m=%b%b%b want res=%h c=%b l/e/m=%b%b%b",
                  tag, got.res, got.carry, got.lt, got.eq, got.gt, e.res, e.carry, e.lt, e.eq, e.gt);
         n_bad++;
      end
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; in_op = 3'($urandom); in_a = DATA_W'($urandom); in_b = DATA_W'($urandom);
         @(posedge clk); #1;
         got = observed();
         n_cmp++;
         if (got !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL %s hold%0d: got res=%h c=%b v=%b rdy=%b want res=%h c=%b v=1 rdy=0",
                     tag, i, got.res, got.carry, out_valid, in_ready, e.res, e.carry);
            n_bad++;
         end
      end
      // Request still asserted on the release edge must not be taken the same cycle.
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", tag, out_valid, in_ready);
         n_bad++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if (out_valid !== 1'b0 || out_res !== '0 || out_carry !== 1'b0 || out_less !== 1'b0 ||
          out_equal !== 1'b0 || out_more !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL reset_state: got v=%b res=%h c=%b l/e/m=%b%b%b rdy=%b want all 0, rdy=1",
                  out_valid, out_res, out_carry, out_less, out_equal, out_more, in_ready);
         n_bad++;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_vectors();
      run_op(3'd0, 8'hFF, 8'h01, 0, "add_ff_01");
      run_op(3'd1, 8'h10, 8'h01, 0, "sub_10_01");
      run_op(3'd1, 8'h01, 8'h02, 0, "sub_01_02");
      run_op(3'd6, 8'h81, 8'h00, 0, "shr_81");
      run_op(3'd7, 8'h81, 8'h00, 0, "shl_81");
      run_op(3'd2, 8'h3C, 8'h0F, 0, "and_3c_0f");
      run_op(3'd3, 8'h35, 8'h53, 0, "cmp_lt");
      run_op(3'd4, 8'h53, 8'h35, 0, "cmp_gt");
      run_op(3'd5, 8'hA7, 8'hA7, 0, "cmp_eq");
   endtask

   task automatic test_backpressure();
      run_op(3'd0, 8'h7E, 8'h45, 5, "backpressure");
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      in_op = 3'd0; in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_res !== '0 || out_carry !== 1'b0 || out_less !== 1'b0 ||
          out_equal !== 1'b0 || out_more !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL midrun_reset: got v=%b res=%h c=%b l/e/m=%b%b%b rdy=%b want all 0, rdy=1",
                  out_valid, out_res, out_carry, out_less, out_equal, out_more, in_ready);
         n_bad++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b0) begin
            $display("FAIL discarded_result cycle%0d: got out_valid=%b want 0", i, out_valid);
            n_bad++;
         end
      end
      run_op(3'd1, 8'h80, 8'h01, 0, "after_reset");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 24; i++) begin
         run_op(3'($urandom), DATA_W'($urandom), DATA_W'($urandom), i % 3, $sformatf("rand%0d", i));
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nibble_serial_alu.md
NIBBLE_SERIAL_ALU -- requirements
Module: nibble_serial_alu

Interface
REQ-001 Parameter NIBBLES, default 2: operand width DATA_W = 4*NIBBLES; NIBBLES SHALL be at least 2.
REQ-002 Single clock, reset asynchronous active-low: clk input 1, rising-edge clock for all state.
REQ-003 rst_n input 1: asynchronous active-low reset.
REQ-004 in_valid input 1: request present.
REQ-005 in_ready output 1: block accepts a request.
REQ-006 in_op input 3: opcode, 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 SHR, 111 SHL.
REQ-007 in_a, in_b input DATA_W: operands.
REQ-008 out_valid output 1: result present.
REQ-009 out_ready input 1: consumer takes the result.
REQ-010 out_res output DATA_W: result.
REQ-011 out_carry output 1: ADD carry-out, SUB no-borrow, shifted-out bit for SHR/SHL, 0 for logic ops.
REQ-012 out_less, out_equal, out_more outputs 1 each: unsigned a<b, a==b, a>b, valid for every opcode.

Function
REQ-013 States: IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 IDLE: in_valid=1 latches op/a/b, clears nibble index and carry, and moves to RUN.
REQ-015 RUN: each cycle processes nibble idx, LSB first, writes result nibble idx, and registers carry; idx wraps after NIBBLES-1 into DONE.
REQ-016 Latency: out_valid SHALL rise exactly NIBBLES clock edges after the accept edge; throughput SHALL be at most one op per NIBBLES+2 cycles.
REQ-017 ADD: nibble carry-in = previous carry-out, initial 0.
REQ-018 SUB: b inverted, initial carry-in 1.
REQ-019 SHR by 1: each nibble's fill bit = bit 0 of the next-higher latched nibble, MSB fill 0, out_carry = a[0].
REQ-020 SHL by 1: each nibble's fill bit = bit 3 of the next-lower latched nibble, LSB fill 0, out_carry = a[DATA_W-1].
REQ-021 Compare: per nibble, a higher nibble's less/more overrides; equal = all nibbles equal; exactly one of the three flags SHALL be 1 in DONE.
REQ-022 DONE: out_valid=1 and all outputs SHALL be held stable until out_ready=1, then the block returns to IDLE the next cycle (no same-cycle re-accept).
REQ-023 in_valid outside IDLE SHALL be ignored; latched operands SHALL NOT change during RUN or DONE.

Reset
REQ-024 rst_n=0 SHALL at any time, including mid-RUN, force IDLE, with out_valid=0, out_res=0, all flags 0, idx=0, and in_ready=1 once the FSM is in IDLE.
REQ-025 A request in flight at reset SHALL be discarded without any result.

Configuration
REQ-026 Macro NIBBLE_ALU_FLAGS_EN defined: extra outputs out_zero (out_res==0) and out_ovf (signed overflow on ADD/SUB, else 0), both registered and valid in DONE.
REQ-027 Macro absent: those ports SHALL NOT exist and all other behaviour SHALL be identical.

Structure
REQ-028 The shared package SHALL hold the opcode enum, the FSM state enum, and the nibble width constant 4.
REQ-029 One sub-module, alu_nibble, SHALL be a combinational 4-bit slice: inputs a, b, op, cin, fill; outputs y, cout, lt, eq, gt.

Verification
REQ-030 ADD a=0xFF b=0x01 -> out_res=0x00, carry=1, out_valid 2 edges after accept.
REQ-031 SUB 0x10-0x01 -> 0x0F, carry=1; SUB 0x01-0x02 -> 0xFF, carry=0, less=1.
REQ-032 SHR a=0x81 -> 0x40, carry=1; SHL a=0x81 -> 0x02, carry=1; AND 0x3C,0x0F -> 0x0C, carry=0.
REQ-033 Compare a=0x35 b=0x53 -> less=1; a=0x53 b=0x35 -> more=1; a=b=0xA7 -> equal=1.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs constant, in_ready=0, extra in_valid ignored.
REQ-035 rst_n pulsed mid-RUN -> IDLE with cleared outputs, and the next request completes correctly.
